// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   XLEN / NREG / RIDX_W : datapath width, register count, index width
//   SRC_ALU / SRC_LSU    : requester indices into the grant vector
package rf_wb_arbiter_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;

  // A selected write-back: destination index plus data.
  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, async active-low reset
//   req[1:0]   : request vector (bit SRC_ALU, bit SRC_LSU)
//   grant[1:0] : one-hot grant, combinational from req and last_grant
// last_grant records the winner of the most recent conflict only; a lone
// requester wins without disturbing the rotation.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last_grant;
  logic conflict;

  assign conflict = req[SRC_ALU] & req[SRC_LSU];

  always_comb begin
    grant = req;
    // On a conflict the source that lost the previous conflict wins.
    if (conflict) begin
      grant[SRC_ALU] = last_grant;
      grant[SRC_LSU] = ~last_grant;
    end
  end

  // Reset to 1 so the ALU path wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        last_grant <= 1'b1;
    else if (conflict) last_grant <= grant[SRC_LSU];
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: arbitrates two write-back sources into a
// registered write stage and tracks a per-register busy scoreboard.
//   clk, reset                 : clock, async active-low reset
//   issue_valid/rd/ready       : decode claims a destination register
//   chk_rs1/2, rs1/2_busy      : combinational hazard lookup
//   reqN_valid/rd/data/ready   : write-back requests (0 = ALU, 1 = LSU/MDU)
//   rf_we/rf_rd/rf_din         : registered write to the register file
//   conflict_cnt               : cycles with both requesters valid
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [$clog2(NREG_P)-1:0] issue_rd,
  output logic                      issue_ready,
  input  logic [$clog2(NREG_P)-1:0] chk_rs1,
  input  logic [$clog2(NREG_P)-1:0] chk_rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  input  logic                      req0_valid,
  input  logic [$clog2(NREG_P)-1:0] req0_rd,
  input  logic [XLEN_P-1:0]         req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [$clog2(NREG_P)-1:0] req1_rd,
  input  logic [XLEN_P-1:0]         req1_data,
  output logic                      req1_ready,
  output logic                      rf_we,
  output logic [$clog2(NREG_P)-1:0] rf_rd,
  output logic [XLEN_P-1:0]         rf_din,
  output logic [31:0]               conflict_cnt
);
  localparam int IW = $clog2(NREG_P);

  logic [1:0]        grant;
  logic              xfer;
  logic [IW-1:0]     sel_rd;
  logic [XLEN_P-1:0] sel_data;
  logic [NREG_P-1:0] busy, busy_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[SRC_ALU];
  assign req1_ready = grant[SRC_LSU];
  assign xfer       = |grant;

  always_comb begin
    sel_rd   = req0_rd;
    sel_data = req0_data;
    if (grant[SRC_LSU]) begin
      sel_rd   = req1_rd;
      sel_data = req1_data;
    end
  end

  // Write stage. x0 transfers are consumed but never reach the RF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we  <= 1'b0;
      rf_rd  <= '0;
      rf_din <= '0;
    end else begin
      rf_we <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_rd  <= sel_rd;
        rf_din <= sel_data;
      end
    end
  end

  // Scoreboard. No bypass: a register committing this cycle still blocks.
  assign issue_ready = issue_valid && ((issue_rd == '0) || !busy[issue_rd]);
  assign rs1_busy    = busy[chk_rs1];
  assign rs2_busy    = busy[chk_rs2];

  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_rd] = 1'b0;
    // Applied after the clear so a same-edge set of the same index wins.
    if (issue_ready && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       conflict_cnt <= '0;
    else if (req0_valid && req1_valid) conflict_cnt <= conflict_cnt + 32'd1;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write-back, round-robin
// conflicts, x0 handling, WAW blocking, set-wins ordering, async reset.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        rs1_busy, rs2_busy;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic [31:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .chk_rs1      (chk_rs1),
    .chk_rs2      (chk_rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .req0_valid   (req0_valid),
    .req0_rd      (req0_rd),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_rd      (req1_rd),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_din       (rf_din),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    tick(); tick();

    // Reset state
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_rd", {27'd0, rf_rd}, 0);
    chk("rst_din", rf_din, 0);
    chk("rst_cnt", conflict_cnt, 0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      chk_rs1 = 5'(i); chk_rs2 = 5'(31 - i); #1;
      chk("idle_busy1", {31'd0, rs1_busy}, 0);
      chk("idle_busy2", {31'd0, rs2_busy}, 0);
    end
    chk("idle_we", {31'd0, rf_we}, 0);

    // Single source: issue rd=5, then write it back from src0
    issue_valid = 1; issue_rd = 5; #1;
    chk("iss5_ready", {31'd0, issue_ready}, 1);
    tick();
    issue_valid = 0; chk_rs1 = 5; chk_rs2 = 5;
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF; #1;
    chk("busy5_pre", {31'd0, rs1_busy}, 1);
    chk("busy5_pre2", {31'd0, rs2_busy}, 1);
    chk("r0_ready", {31'd0, req0_ready}, 1);
    chk("r1_ready_idle", {31'd0, req1_ready}, 0);
    tick();
    req0_valid = 0; #1;
    chk("wb5_we", {31'd0, rf_we}, 1);
    chk("wb5_rd", {27'd0, rf_rd}, 5);
    chk("wb5_din", rf_din, 32'hDEADBEEF);
    chk("busy5_during_we", {31'd0, rs1_busy}, 1);
    tick();
    chk("wb5_we_off", {31'd0, rf_we}, 0);
    chk("busy5_post", {31'd0, rs1_busy}, 0);

    // Conflict: round robin starting with src0; losers hold their request
    req0_valid = 1; req0_rd = 1; req0_data = 32'hA1;
    req1_valid = 1; req1_rd = 9; req1_data = 32'hB9; #1;
    chk("c1_g0", {30'd0, req1_ready, req0_ready}, 32'b01);
    tick();
    chk("c1_rd", {27'd0, rf_rd}, 1);
    chk("c1_din", rf_din, 32'hA1);
    req0_rd = 2; req0_data = 32'hA2; #1;
    chk("c2_g1", {30'd0, req1_ready, req0_ready}, 32'b10);
    tick();
    chk("c2_rd", {27'd0, rf_rd}, 9);
    chk("c2_din", rf_din, 32'hB9);
    req1_rd = 10; req1_data = 32'hBA; #1;
    chk("c3_g0", {30'd0, req1_ready, req0_ready}, 32'b01);
    tick();
    chk("c3_rd", {27'd0, rf_rd}, 2);
    req0_rd = 3; req0_data = 32'hA3; #1;
    chk("c4_g1", {30'd0, req1_ready, req0_ready}, 32'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("c4_rd", {27'd0, rf_rd}, 10);
    chk("c4_we", {31'd0, rf_we}, 1);
    chk("c_cnt", conflict_cnt, 4);

    // x0: accepted, no RF write, busy untouched
    req1_valid = 1; req1_rd = 0; req1_data = 32'h1234; #1;
    chk("x0_ready", {31'd0, req1_ready}, 1);
    tick();
    req1_valid = 0; chk_rs1 = 0; #1;
    chk("x0_we", {31'd0, rf_we}, 0);
    chk("x0_busy", {31'd0, rs1_busy}, 0);
    chk("x0_cnt", conflict_cnt, 4);
    issue_valid = 1; issue_rd = 0; #1;
    chk("iss0_ready", {31'd0, issue_ready}, 1);
    tick();
    chk("iss0_busy", {31'd0, rs1_busy}, 0);

    // WAW: rd=7 blocks until its write-back commits
    issue_rd = 7; chk_rs1 = 7; #1;
    chk("iss7_ready", {31'd0, issue_ready}, 1);
    tick();
    chk("iss7_again", {31'd0, issue_ready}, 0);
    tick();
    req0_valid = 1; req0_rd = 7; req0_data = 32'h77; #1;
    chk("iss7_blocked", {31'd0, issue_ready}, 0);
    tick();
    req0_valid = 0; #1;
    chk("wb7_we", {31'd0, rf_we}, 1);
    chk("iss7_nobypass", {31'd0, issue_ready}, 0);
    tick();
    chk("busy7_clear", {31'd0, rs1_busy}, 0);
    chk("iss7_free", {31'd0, issue_ready}, 1);
    tick();
    issue_valid = 0; #1;
    chk("busy7_reset", {31'd0, rs1_busy}, 1);

    // Set wins: issue rd=8 on the edge that commits an unissued write to 8
    req0_valid = 1; req0_rd = 8; req0_data = 32'h88; chk_rs2 = 8;
    tick();
    req0_valid = 0; issue_valid = 1; issue_rd = 8; #1;
    chk("wb8_we", {31'd0, rf_we}, 1);
    chk("iss8_ready", {31'd0, issue_ready}, 1);
    tick();
    issue_valid = 0; #1;
    chk("busy8_setwins", {31'd0, rs2_busy}, 1);

    // Async reset in the middle of a transfer
    req0_valid = 1; req0_rd = 3; req0_data = 32'h33;
    tick();
    req0_valid = 0; #1;
    chk("pre_rst_we", {31'd0, rf_we}, 1);
    reset = 1'b0; #1;
    chk("arst_we", {31'd0, rf_we}, 0);
    chk("arst_rd", {27'd0, rf_rd}, 0);
    chk("arst_din", rf_din, 0);
    chk("arst_cnt", conflict_cnt, 0);
    chk("arst_busy8", {31'd0, rs2_busy}, 0);
    chk("arst_busy7", {31'd0, rs1_busy}, 0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
